// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
// Shared definitions for the FIFO-drain UART transmitter:
//   - tx_state_e : FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3,
//                  STOP=4), 3 bits wide.
//   - DATA_BITS  : payload bits per frame.
//   - IDLE_LEVEL : level of the serial line when no frame is in flight.
//   - evenParity : even parity of one payload byte. It is only called when
//                  the build defines FIFO_UART_TX_PARITY_EN.
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic logic evenParity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_if
// FIFO-side bus between the 32x8 FIFO and the UART drain stage.
//   Fifo_Data       : FIFO Output byte. It is show-ahead and valid while
//                     Fifo_Empty=0.
//   Fifo_Empty      : FIFO Empty flag.
//   Fifo_Enable     : FIFO Enable, a single-cycle pop strobe.
//   Fifo_Read_Write : FIFO Read_Write. It is always 1 (read).
// Modports:
//   master : the transmitter. It drives Enable/Read_Write and consumes Data/Empty.
//   slave  : the FIFO side.
// ---------------------------------------------------------------------------
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic [DATA_BITS-1:0] Fifo_Data;
  logic                 Fifo_Empty;
  logic                 Fifo_Enable;
  logic                 Fifo_Read_Write;

  modport master (
    input  Fifo_Data,
    input  Fifo_Empty,
    output Fifo_Enable,
    output Fifo_Read_Write
  );

  modport slave (
    output Fifo_Data,
    output Fifo_Empty,
    input  Fifo_Enable,
    input  Fifo_Read_Write
  );

endinterface

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Bit-period counter for the UART transmitter. It counts 0..CLKS_PER_BIT-1
// and wraps to 0 on each bit boundary. o_tick is high during the last cycle of
// every bit period. A synchronous clear holds the counter at 0. The FSM uses
// the clear while it is idle, so that every frame starts with a full bit
// period.
// Ports:
//   clk     : system clock (rising edge)
//   rst_n   : asynchronous active-low reset
//   i_clear : synchronous clear of the counter
//   o_tick  : one-cycle strobe on the last cycle of each bit
// Parameter:
//   CLKS_PER_BIT : clock cycles per serial bit, 2..65535
// ---------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  assign o_tick = (r_count == LAST);

  // The counter wraps on the tick, so a bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Drain stage for the 32x8 FIFO. Whenever the FIFO holds data and Tx_En is
// high, the stage pops one byte and sends it as an asynchronous UART frame:
// a start bit, 8 data bits LSB first, an optional even-parity bit, and a stop
// bit.
// Configuration macro: FIFO_UART_TX_PARITY_EN. When it is defined, the stage
// sends 8E1 frames (11 bits). When it is undefined, it sends 8N1 frames
// (10 bits).
// Ports:
//   CLK    : system clock (rising edge)
//   Reset  : asynchronous active-low reset. It aborts any frame in flight.
//   Tx_En  : permits a new frame. It is sampled only in IDLE.
//   fifo   : FIFO bus (master side), carrying Data, Empty, Enable and Read_Write
//   Tx     : serial line. It idles high.
//   Busy   : high from the pop cycle through the last stop-bit cycle
// Parameter:
//   CLKS_PER_BIT : clock cycles per serial bit, 2..65535
// ---------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Tx_En,
  fifo_uart_tx_if.master    fifo,
  output logic              Tx,
  output logic              Busy
);

  tx_state_e            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bitIdx;
  logic                 r_tx;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_pop;
  logic w_tick;
  logic w_baudClear;

  // The pop is combinational, so the FIFO registers it on the same edge that
  // latches the byte. Reset gates the pop, so no strobe can escape while
  // Reset is held.
  assign w_pop       = Reset & (r_state == IDLE) & Tx_En & ~fifo.Fifo_Empty;
  assign w_baudClear = (r_state == IDLE);

  assign fifo.Fifo_Enable     = w_pop;
  assign fifo.Fifo_Read_Write = 1'b1;
  assign Tx                   = r_tx;
  assign Busy                 = (r_state != IDLE) | w_pop;

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (CLK),
    .rst_n   (Reset),
    .i_clear (w_baudClear),
    .o_tick  (w_tick)
  );

  // The transmit FSM. r_tx is loaded with the level of the next bit on the
  // same edge as the state change, so the line is a clean registered output.
  // The byte stays in r_shift for the whole frame, so FIFO changes during
  // the frame have no effect.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitIdx <= '0;
      r_tx     <= IDLE_LEVEL;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= IDLE_LEVEL;
          if (w_pop) begin
            r_shift  <= fifo.Fifo_Data;
            r_bitIdx <= '0;
            r_tx     <= 1'b0;
            r_state  <= START;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= evenParity(fifo.Fifo_Data);
`endif
          end
        end

        START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end
        end

        DATA: begin
          if (w_tick) begin
            r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
            if (r_bitIdx == 3'(DATA_BITS - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= PARITY;
`else
              r_tx    <= IDLE_LEVEL;
              r_state <= STOP;
`endif
            end else begin
              r_tx <= r_shift[1];
            end
          end
        end

`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_tx    <= IDLE_LEVEL;
            r_state <= STOP;
          end
        end
`endif

        STOP: begin
          if (w_tick) begin
            r_tx    <= IDLE_LEVEL;
            r_state <= IDLE;
          end
        end

        default: begin
          r_tx    <= IDLE_LEVEL;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 32x8 FIFO: pops one byte at a time whenever the FIFO is non-empty and serializes it as an asynchronous UART frame (start, 8 data bits LSB first, optional parity, stop). Its FIFO-side outputs drive the FIFO's Enable and Read_Write inputs directly, and it consumes the FIFO's Output and Empty. It is the byte-to-line stage of the data path.

## Interface
Parameters:
- CLKS_PER_BIT, 16, CLK cycles per serial bit; legal range 2..65535.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low; clears all state immediately.
- Tx_En  input  1  permits starting a new frame; sampled only in IDLE.
- Fifo_Data  input  8  FIFO Output; show-ahead, valid while Fifo_Empty=0.
- Fifo_Empty  input  1  FIFO Empty flag.
- Fifo_Enable  output  1  FIFO Enable; single-cycle pop strobe.
- Fifo_Read_Write  output  1  FIFO Read_Write; constant 1 (read), including during reset.
- Tx  output  1  serial line; idles high.
- Busy  output  1  high from the pop cycle through the last stop-bit cycle.

## Operation
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE: when Tx_En=1 and Fifo_Empty=0, assert Fifo_Enable for exactly one cycle, latch Fifo_Data into the shift register on the same edge, clear the bit counter and baud counter, then go to START.
- START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: Tx=shift[0]. After each CLKS_PER_BIT cycles, shift right and increment the 3-bit index. After index 7 completes, go to PARITY if compiled in, otherwise to STOP.
- PARITY: Tx=^byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: Tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, and wraps to 0 on each bit boundary.
- Fifo_Enable is never asserted outside IDLE. It is never asserted when Fifo_Empty=1, which prevents underflow of the FIFO pointers.
- If Tx_En deasserts mid-frame, the current frame completes and no further pop occurs.
- Fifo_Data and Fifo_Empty changes during a frame are ignored; the byte is held in the local shift register.
- Reset asserted mid-frame: the frame is aborted and Tx returns high asynchronously. The popped byte is lost; it is not re-pushed.

## Timing
- Reset values: Tx=1, Busy=0, Fifo_Enable=0, Fifo_Read_Write=1, state IDLE.
- Pop latency: Fifo_Enable is asserted combinationally from IDLE & Tx_En & ~Fifo_Empty and registered by the FIFO on the same edge the byte is latched.
- Start bit begins on the cycle after the pop.
- Frame length is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity, plus 1 IDLE/pop cycle.
- Back-to-back bytes are separated by exactly one cycle of Tx=1 beyond the stop bit. That cycle is the next pop cycle.
- Busy rises on the pop cycle and falls on the first IDLE cycle after STOP.

## Configuration
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: the PARITY state is present, one even-parity bit follows the data bits, and frames are 11 bits.
- Undefined: the PARITY state and parity logic are not compiled, and frames are 10 bits (8N1).

## Structure
- Shared package fifo_uart_pkg holds:
  - the state enum (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), 3 bits;
  - DATA_BITS=8;
  - the idle line level constant.
- Sub-module baud_tick_gen (parameter CLKS_PER_BIT): a counter with a synchronous clear from the FSM, outputting a one-cycle tick on the last cycle of each bit. The FSM advances only on a tick.

## Test plan
- Reset mid-frame: assert Reset during DATA with CLKS_PER_BIT=4 -> Tx=1, Busy=0 and Fifo_Enable=0 immediately, with no clock needed; after release, IDLE resumes with the next FIFO byte.
- Single byte: CLKS_PER_BIT=4, FIFO holds 0xA5, Tx_En=1 -> one Fifo_Enable pulse, then Tx = 0 for 4 cycles, bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; Busy high for 41 cycles.
- Back-to-back: FIFO holds 0x00, 0xFF -> two pops 41 cycles apart; the gap between the first stop bit and the second start bit is exactly 1 cycle.
- Empty/Tx_En gating: Fifo_Empty=1, or Tx_En=0 with data present -> Fifo_Enable stays 0 and Tx stays 1 over 100 cycles. Dropping Tx_En mid-frame lets the frame finish and blocks the next pop.
- Drain full FIFO: push 32 bytes 0x00..0x1F -> exactly 32 pops; Fifo_Empty rises after the 32nd pop and the output bytes match in order.
- Parity (FIFO_UART_TX_PARITY_EN defined): 0x07 -> parity bit 1 and frame length 44 cycles; 0x03 -> parity bit 0.
